// File: rtl/mem_wb_stage_pkg.sv
// Shared RV32I opcode/funct3 constants and decode helpers for the memory/writeback stage.
package mem_wb_stage_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  localparam logic [2:0] FNC_CSRRW  = 3'b001;
  localparam logic [2:0] FNC_CSRRWI = 3'b101;

  // Opcodes whose result lands in the register file.
  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      OPC_ARI_RTYPE, OPC_ARI_ITYPE, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      default:                      writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_align.sv
// Combinational byte-lane logic: store mask/data replication and load extraction/extension.
module mem_align
  import mem_wb_stage_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  output logic [3:0]  o_mask,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;
  logic [15:0] w_half;

  assign w_shifted = i_load_word >> {i_off, 3'b000};
  // Halfword accesses ignore addr[0]: only the upper/lower half is selectable.
  assign w_half    = i_off[1] ? i_load_word[31:16] : i_load_word[15:0];

  always_comb begin
    o_mask       = 4'b0000;
    o_store_word = i_store_data;
    case (i_funct3)
      FNC_SB: begin
        o_mask       = 4'b0001 << i_off;
        o_store_word = {4{i_store_data[7:0]}};
      end
      FNC_SH: begin
        o_mask       = 4'b0011 << {i_off[1], 1'b0};
        o_store_word = {2{i_store_data[15:0]}};
      end
      FNC_SW:  o_mask = 4'b1111;
      default: o_mask = 4'b0000;
    endcase
  end

  always_comb begin
    o_load_data = i_load_word;
    case (i_funct3)
      FNC_LB:  o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      FNC_LBU: o_load_data = {24'h0, w_shifted[7:0]};
      FNC_LH:  o_load_data = {{16{w_half[15]}}, w_half};
      FNC_LHU: o_load_data = {16'h0, w_half};
      default: o_load_data = i_load_word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: WB register, D-cache request FSM, writeback mux and tohost CSR.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        x_valid,
  input  logic [31:0] x_inst,
  input  logic [31:0] x_alu_result,
  input  logic [31:0] x_pc_plus4,
  input  logic [31:0] x_store_data,
  input  logic        x_dmem_re,
  input  logic        x_memrw,
  input  logic [31:0] x_csr_data,
  output logic        dcache_req_valid,
  input  logic        dcache_req_ready,
  output logic [31:0] dcache_addr,
  output logic [3:0]  dcache_we,
  output logic [31:0] dcache_din,
  input  logic        dcache_resp_valid,
  input  logic [31:0] dcache_dout,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] wb_inst,
  output logic        stall,
  output logic [31:0] csr_tohost,
  output logic [0:0]  dbg_fsm_state
);

  localparam logic [0:0] ST_ISSUE = 1'b0;
  localparam logic [0:0] ST_WAIT  = 1'b1;

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_alu;
  logic [31:0] r_pc4;
  logic [31:0] r_sdata;
  logic        r_re;
  logic        r_memrw;
  logic [31:0] r_csr_data;
  logic [0:0]  r_state;
  logic [31:0] r_tohost;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_memop;
  logic        w_is_load;
  logic        w_fire;
  logic        w_done;
  logic        w_stall;
  logic [3:0]  w_mask;
  logic [31:0] w_store_word;
  logic [31:0] w_load_data;

  assign w_opcode  = r_inst[6:0];
  assign w_funct3  = r_inst[14:12];
  assign w_memop   = r_valid & (r_re | r_memrw);
  assign w_is_load = r_re;

  // Request handshake: dcache_req_valid rises only in ISSUE for a memop and, once up,
  // holds with address/mask/data stable until the cycle where dcache_req_ready is also 1.
  // A load then waits in WAIT for dcache_resp_valid; responses seen in ISSUE are ignored.
  assign dcache_req_valid = w_memop & (r_state == ST_ISSUE);
  assign w_fire           = dcache_req_valid & dcache_req_ready;
  assign w_done           = (r_state == ST_ISSUE) ? (w_fire & ~w_is_load)
                                                  : dcache_resp_valid;
  assign w_stall          = w_memop & ~w_done;

  mem_align u_align (
    .i_off        (r_alu[1:0]),
    .i_funct3     (w_funct3),
    .i_store_data (r_sdata),
    .i_load_word  (dcache_dout),
    .o_mask       (w_mask),
    .o_store_word (w_store_word),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_inst     <= NOP_INST;
      r_alu      <= 32'h0;
      r_pc4      <= 32'h0;
      r_sdata    <= 32'h0;
      r_re       <= 1'b0;
      r_memrw    <= 1'b0;
      r_csr_data <= 32'h0;
    end else if (!w_stall) begin
      r_valid    <= x_valid;
      r_inst     <= x_valid ? x_inst : NOP_INST;
      r_alu      <= x_alu_result;
      r_pc4      <= x_pc_plus4;
      r_sdata    <= x_store_data;
      r_re       <= x_valid & x_dmem_re;
      r_memrw    <= x_valid & x_memrw;
      r_csr_data <= x_csr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_ISSUE;
    end else if (r_state == ST_ISSUE) begin
      if (w_fire && w_is_load) r_state <= ST_WAIT;
    end else if (dcache_resp_valid) begin
      r_state <= ST_ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tohost <= 32'h0;
    end else if (r_valid && (w_opcode == OPC_CSR) && (r_inst[31:20] == TOHOST_ADDR) &&
                 ((w_funct3 == FNC_CSRRW) || (w_funct3 == FNC_CSRRWI))) begin
      r_tohost <= r_csr_data;
    end
  end

  assign dcache_addr = {r_alu[31:2], 2'b00};
  assign dcache_we   = r_memrw ? w_mask : 4'b0000;
  assign dcache_din  = w_store_word;

  always_comb begin
    wb_data = r_alu;
    if (w_opcode == OPC_LOAD)                               wb_data = w_load_data;
    else if ((w_opcode == OPC_JAL) || (w_opcode == OPC_JALR)) wb_data = r_pc4;
    else if (w_opcode == OPC_CSR)                           wb_data = 32'h0;
  end

  assign wb_rd         = r_inst[11:7];
  assign wb_inst       = r_inst;
  assign wb_we         = r_valid & (wb_rd != 5'd0) & writes_rd(w_opcode) & ~w_stall;
  assign stall         = w_stall;
  assign csr_tohost    = r_tohost;
  assign dbg_fsm_state = r_state;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/writeback stage of the 3-stage RV32I pipeline, directly downstream of the X stage. It registers the X-stage result and control, issues the data-cache request for loads and stores, and aligns and extends load data. It produces the register-file writeback and the `Mem_WB_inst` forwarding source that the X stage consumes. It owns the `tohost` CSR and raises `stall` to freeze F/D/X while a memory access is outstanding.

## Interface
- `NOP_INST`, default 32'h0000_0013: instruction shown on `wb_inst` when the stage holds a bubble.
- `TOHOST_ADDR`, default 12'h51E: CSR address written by `csrw`/`csrwi`.
- `clk`  in  1: the only clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low. The stage is in reset when `reset` is 0 at a rising edge of `clk`.
- `x_valid`  in  1: the X stage holds a real instruction.
- `x_inst`  in  32: the X-stage instruction.
- `x_alu_result`  in  32: ALU output; this is the memory address for loads and stores.
- `x_pc_plus4`  in  32: link value for JAL/JALR.
- `x_store_data`  in  32: forwarded rs2 value.
- `x_dmem_re`  in  1: the instruction is a load.
- `x_memrw`  in  1: the instruction is a store.
- `x_csr_data`  in  32: CSR write value produced by the X stage.
- `dcache_req_valid`  out  1: request valid.
- `dcache_req_ready`  in  1: the cache accepts the request.
- `dcache_addr`  out  32: word-aligned address, `{addr[31:2],2'b00}`.
- `dcache_we`  out  4: byte write mask; 0 for loads.
- `dcache_din`  out  32: lane-replicated store data.
- `dcache_resp_valid`  in  1: load data valid.
- `dcache_dout`  in  32: raw load word.
- `wb_we`  out  1: register-file write enable.
- `wb_rd`  out  5: destination register.
- `wb_data`  out  32: writeback and forwarding data.
- `wb_inst`  out  32: the WB-stage instruction (forwarding source for X).
- `stall`  out  1: freezes F/D/X and the WB register.
- `csr_tohost`  out  32: `tohost` value.

## Operation
- **WB register.** On each edge with `reset`=1 and `stall`=0, the register captures all `x_*` inputs. If `x_valid`=0, it captures a bubble: `wb_valid`=0 and `wb_inst`=`NOP_INST`. When `stall`=1, the register holds its contents.
- **Memory operation.** An instruction is a memory operation (`memop`) when it is valid and has `dmem_re` or `memrw` set.
- **FSM states.** The FSM has two states, ISSUE and WAIT; reset state is ISSUE.
  - ISSUE with `memop`: drive `dcache_req_valid`=1.
  - ISSUE, fire on a store (`req_valid & req_ready`): the store is done this cycle; stay in ISSUE.
  - ISSUE, fire on a load: go to WAIT.
  - ISSUE, no fire: stay in ISSUE with the request held stable.
  - WAIT: `dcache_req_valid`=0. On `dcache_resp_valid`, the load is done and the FSM returns to ISSUE.
- **Stall.** `stall = memop & !done`.
- **Responses.** A response never counts in the same cycle as its request fire. `dcache_resp_valid` in ISSUE is ignored.
- **Store lanes.** `off` = `addr[1:0]`.
  - SB: mask `4'b0001<<off`, data `{4{b}}`.
  - SH: mask `4'b0011<<{off[1],1'b0}`, data `{2{h}}`.
  - SW: mask `4'b1111`.
  - Misaligned accesses are not trapped; the low address bits are truncated (SH/LH ignore `addr[0]`, SW/LW ignore `addr[1:0]`).
- **Load extension.** The byte or halfword is selected by `off`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Writeback data selection.**
  - Load: the extended `dcache_dout`.
  - JAL/JALR: `pc_plus4`.
  - CSR: 0, and no register write.
  - All other instructions: `alu_result`.
- **Writeback enable.** `wb_we` = valid, `rd`≠0, opcode in {R, I, LOAD, LUI, AUIPC, JAL, JALR}, and not stalled.
  - A load asserts `wb_we` only in its done cycle.
- **tohost.** When a valid CSR instruction with csr field == `TOHOST_ADDR` and funct3 CSRRW/CSRRWI is in WB, `csr_tohost` <= `x_csr_data` as registered into WB, at the end of that cycle.

## Timing
- **Non-memory instructions.** Writeback occurs in the cycle after X; `wb_*` are combinational from the WB register.
- **Store.** Minimum 1 cycle in WB, when `req_ready`=1. Each cycle of `req_ready`=0 adds one stall cycle.
- **Load.** Minimum 2 cycles in WB (fire, then response). Data goes to `wb_data` combinationally in the response cycle.
- **Back-to-back memory operations.** Supported; the next instruction enters WB on the edge that ends the done cycle.
- **Reset values.** `wb_valid`=0, `wb_inst`=`NOP_INST`, FSM=ISSUE, `csr_tohost`=0.
  - Consequently `dcache_req_valid`=0, `wb_we`=0, `stall`=0, `wb_rd`=0, `wb_data`=0.
- **Reset mid-access.** A pending request or load is dropped. A response arriving after reset is ignored.

## Structure
- **Shared constants.** Opcode and funct3 constants come from the shared `Opcode.vh`. `FNC_LB`..`FNC_LHU` and `FNC_SB`..`FNC_SW` are added there if missing.
- **FSM encoding.** The ISSUE/WAIT encoding is local to this module.
- **Sub-module.** One sub-module, `mem_align`: purely combinational store mask/data generation and load extraction/extension, reused by the future I-cache bypass path.

## Test plan
- **ALU writeback.** `addi x5,x0,7` with `x_alu_result`=7 → the next cycle shows `wb_we`=1, `wb_rd`=5, `wb_data`=7, `stall`=0.
- **Signed byte load.** LB at address 0x1003, `dcache_dout`=0x80FF_FF12, response 3 cycles after fire → `stall`=1 for 3 cycles. In the response cycle, `wb_data`=0xFFFF_FF80 and `wb_we`=1.
- **Store with back-pressure.** SH at address 0x2002, rs2=0x0000_BEEF, `req_ready` low for 2 cycles → request held stable. `dcache_addr`=0x2000, `dcache_we`=4'b1100, `dcache_din`=0xBEEF_BEEF; `stall` drops in the fire cycle.
- **tohost write.** `csrw 0x51E`, `x_csr_data`=1 → `csr_tohost`=1 after the WB cycle; `wb_we`=0.
- **Reset during WAIT.** Reset low while in WAIT, then a late `dcache_resp_valid` → no `wb_we`, FSM=ISSUE, `wb_inst`=0x13.
- **x0 and bubbles.** LW with `rd`=x0 → `wb_we`=0, but the stall and handshake still complete. A bubble (`x_valid`=0) → `wb_inst`=0x13 and no request.
